// File: rtl/bus_map_pkg.sv
// Address map shared by the data-bus responder: MMIO register offsets, STATUS
// bit positions and the region decode used by the read/write paths.
package bus_map_pkg;

    localparam logic [31:0] OUT_OFS   = 32'h0;
    localparam logic [31:0] STAT_OFS  = 32'h4;
    localparam logic [31:0] START_OFS = 32'h8;

    localparam int OVF_BIT   = 31;
    localparam int START_BIT = 8;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_OUT,
        REG_STAT,
        REG_START,
        REG_NONE
    } addr_region_e;

    // MMIO registers are word registers: the low two address bits select a lane only.
    function automatic addr_region_e decode_region(
        input logic [31:0] adr,
        input logic [31:0] ram_bytes,
        input logic [31:0] base
    );
        logic [31:0] word_adr;
        word_adr = {adr[31:2], 2'b00};
        if (adr < ram_bytes)                   return REG_RAM;
        else if (word_adr == base + OUT_OFS)   return REG_OUT;
        else if (word_adr == base + STAT_OFS)  return REG_STAT;
        else if (word_adr == base + START_OFS) return REG_START;
        else                                   return REG_NONE;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head; a push into a full FIFO is only
// accepted when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_bus_responder.sv
// Data-side slave for the single-cycle core: byte-lane data RAM plus an MMIO
// window with an output FIFO, a STATUS register and a sticky start latch.
module data_bus_responder
    import bus_map_pkg::*;
#(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        MemWrite,
    input  logic        ByteMem,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow
);
    localparam int          RAM_AW    = $clog2(RAM_WORDS);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    addr_region_e       region;
    logic [RAM_AW-1:0]  ram_idx;
    logic [1:0]         lane;
    logic [31:0]        ram [RAM_WORDS];
    logic [31:0]        word_rd;
    logic [31:0]        push_data;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic               ovf_set;
    logic               start_latch;

    assign region  = decode_region(DataAdr, RAM_BYTES, MMIO_BASE);
    assign ram_idx = DataAdr[RAM_AW+1:2];
    assign lane    = DataAdr[1:0];

    // Output stream: a beat transfers on a rising edge where out_valid && out_ready;
    // out_valid never depends on out_ready, and out_data holds until accepted.
    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;
    assign fifo_push = MemWrite && (region == REG_OUT);
    assign push_data = ByteMem ? {24'b0, WriteData[7:0]} : WriteData;
    // A full FIFO only drops the push when nothing leaves on the same edge.
    assign ovf_set   = fifo_push && fifo_full && !fifo_pop;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (push_data),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (MemWrite && region == REG_RAM) begin
            if (ByteMem) begin
                ram[ram_idx][{lane, 3'b000} +: 8] <= WriteData[7:0];
            end else begin
                ram[ram_idx] <= WriteData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow    <= 1'b0;
            start_latch <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (MemWrite && region == REG_STAT && WriteData[OVF_BIT]) begin
                overflow <= 1'b0;
            end
            if (start) begin
                start_latch <= 1'b1;
            end else if (MemWrite && region == REG_START) begin
                start_latch <= 1'b0;
            end
        end
    end

    always_comb begin
        word_rd = '0;
        case (region)
            REG_RAM: word_rd = ram[ram_idx];
            REG_STAT: begin
                word_rd[OVF_BIT]   = overflow;
                word_rd[START_BIT] = start_latch;
                word_rd[7:0]       = 8'(fifo_count);
            end
            REG_START: word_rd[0] = start_latch;
            default:   word_rd = '0;
        endcase
    end

    assign ReadData = ByteMem ? {24'b0, word_rd[{lane, 3'b000} +: 8]} : word_rd;

endmodule

// File: tb/tb_data_bus_responder.sv
// Randomized and directed bench for data_bus_responder against a queue/array
// reference model of the memory map, FIFO, overflow flag and start latch.
module tb_data_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        MemWrite;
    logic        ByteMem;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] ram_m [64];
    logic [31:0] exp_q [$];
    logic        ovf_m   = 1'b0;
    logic        latch_m = 1'b0;

    logic [31:0] last_rd;
    logic [31:0] last_od;

    always #5 clk = ~clk;

    data_bus_responder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .MemWrite  (MemWrite),
        .ByteMem   (ByteMem),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] adr, input logic bm);
        logic [31:0] w;
        w = 0;
        if (adr < 256) w = ram_m[adr / 4];
        else if ((adr & ~32'd3) == 32'h404)
            w = (ovf_m ? 32'h8000_0000 : 0) + (latch_m ? 256 : 0) + exp_q.size();
        else if ((adr & ~32'd3) == 32'h408) w = latch_m ? 1 : 0;
        if (bm) w = (w >> (8 * (adr % 4))) & 255;
        return w;
    endfunction

    task automatic model_step(input logic mw, input logic bm, input logic [31:0] adr,
                              input logic [31:0] wd, input logic st, input logic rdy);
        logic        pop, push, ovf_now;
        logic [31:0] pv, w;
        int          sh;
        pop     = (exp_q.size() > 0) && rdy;
        push    = mw && ((adr & ~32'd3) == 32'h400);
        pv      = bm ? (wd & 255) : wd;
        ovf_now = push && exp_q.size() == 8 && !pop;
        if (pop) void'(exp_q.pop_front());
        if (push && !ovf_now) exp_q.push_back(pv);
        if (ovf_now) ovf_m = 1'b1;
        else if (mw && (adr & ~32'd3) == 32'h404 && wd[31]) ovf_m = 1'b0;
        if (st) latch_m = 1'b1;
        else if (mw && (adr & ~32'd3) == 32'h408) latch_m = 1'b0;
        if (mw && adr < 256) begin
            if (bm) begin
                sh = 8 * (adr % 4);
                w  = ram_m[adr / 4];
                ram_m[adr / 4] = (w & ~(32'hFF << sh)) | ((wd & 255) << sh);
            end else begin
                ram_m[adr / 4] = wd;
            end
        end
    endtask

    // One bus cycle: drive at negedge, check pre-edge outputs, commit model at posedge.
    task automatic cycle(input logic mw, input logic bm, input logic [31:0] adr,
                         input logic [31:0] wd, input logic st, input logic rdy);
        @(negedge clk);
        reset = 1'b0; MemWrite = mw; ByteMem = bm; DataAdr = adr;
        WriteData = wd; start = st; out_ready = rdy;
        #1;
        last_rd = ReadData;
        last_od = out_data;
        check("read_data", ReadData, model_read(adr, bm));
        check("out_valid", {31'b0, out_valid}, (exp_q.size() != 0) ? 1 : 0);
        check("out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : 0);
        check("overflow", {31'b0, overflow}, {31'b0, ovf_m});
        @(posedge clk);
        model_step(mw, bm, adr, wd, st, rdy);
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        reset = 1'b1; MemWrite = 1'b0; ByteMem = 1'b0; DataAdr = 0;
        WriteData = 0; start = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        exp_q.delete();
        ovf_m   = 1'b0;
        latch_m = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] v, input logic rdy);
        cycle(1'b1, 1'b0, 32'h400, v, 1'b0, rdy);
    endtask

    task automatic read_status();
        cycle(1'b0, 1'b0, 32'h404, 0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] adr;
        int          pick;

        reset = 1'b1; start = 1'b0; MemWrite = 1'b0; ByteMem = 1'b0;
        DataAdr = 0; WriteData = 0; out_ready = 1'b0;
        reset_cycle();
        reset_cycle();

        read_status();
        check("reset_status", last_rd, 32'h0);

        // give every RAM word a known value
        for (int i = 0; i < 64; i++) cycle(1'b1, 1'b0, 32'(4 * i), $urandom, 1'b0, 1'b0);

        // word store / load, unmapped access
        cycle(1'b1, 1'b0, 32'h10, 32'h11223344, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h10, 0, 1'b0, 1'b0);
        check("t1_load", last_rd, 32'h11223344);
        cycle(1'b1, 1'b0, 32'h500, 32'hDEADBEEF, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h500, 0, 1'b0, 1'b0);
        check("t1_unmapped", last_rd, 32'h0);
        cycle(1'b0, 1'b0, 32'h10, 0, 1'b0, 1'b0);
        check("t1_ram_kept", last_rd, 32'h11223344);

        // byte store / byte load
        cycle(1'b1, 1'b1, 32'h11, 32'hFFFF_FFAB, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h10, 0, 1'b0, 1'b0);
        check("t2_word", last_rd, 32'h1122AB44);
        cycle(1'b0, 1'b1, 32'h11, 0, 1'b0, 1'b0);
        check("t2_ldrb", last_rd, 32'h000000AB);

        // fill, overflow, drain
        for (int i = 1; i <= 8; i++) push_word(32'(i), 1'b0);
        read_status();
        check("t3_full_status", last_rd, 32'h0000_0008);
        push_word(32'd9, 1'b0);
        read_status();
        check("t3_ovf_status", last_rd, 32'h8000_0008);
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b1);
            check("t3_drain", last_od, 32'(i));
        end
        read_status();
        check("t3_empty_status", last_rd, 32'h8000_0000);

        // clear overflow, then push+pop on a full FIFO
        cycle(1'b1, 1'b0, 32'h404, 32'h8000_0000, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) push_word(32'h10 + 32'(i), 1'b0);
        push_word(32'h5, 1'b1);
        read_status();
        check("t4_status", last_rd, 32'h0000_0008);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b1);
        check("t4_last", last_od, 32'h5);

        // start latch
        cycle(1'b0, 1'b0, 32'h0, 0, 1'b1, 1'b0);
        read_status();
        check("t5_status", last_rd, 32'h0000_0100);
        cycle(1'b0, 1'b0, 32'h408, 0, 1'b0, 1'b0);
        check("t5_start_rd", last_rd, 32'h1);
        cycle(1'b1, 1'b0, 32'h408, 0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h408, 0, 1'b0, 1'b0);
        check("t5_cleared", last_rd, 32'h0);
        cycle(1'b1, 1'b0, 32'h408, 0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 32'h408, 0, 1'b0, 1'b0);
        check("t5_set_wins", last_rd, 32'h1);

        // reset mid-stream
        for (int i = 0; i < 3; i++) push_word(32'hA0 + 32'(i), 1'b0);
        push_word(32'd1, 1'b0);
        reset_cycle();
        cycle(1'b0, 1'b0, 32'h404, 0, 1'b0, 1'b0);
        check("t6_status", last_rd, 32'h0);
        check("t6_valid", {31'b0, out_valid}, 32'h0);
        cycle(1'b0, 1'b0, 32'h10, 0, 1'b0, 1'b0);
        check("t6_ram", last_rd, 32'h1122AB44);

        // randomized traffic over every region
        for (int n = 0; n < 600; n++) begin
            pick = $urandom_range(0, 9);
            case (pick)
                0, 1, 2: adr = $urandom_range(0, 255);
                3, 4:    adr = 32'h400 + $urandom_range(0, 3);
                5:       adr = 32'h404 + $urandom_range(0, 3);
                6:       adr = 32'h408 + $urandom_range(0, 3);
                7:       adr = 32'h40C;
                8:       adr = 32'h100 + $urandom_range(0, 32'h2FF);
                default: adr = $urandom;
            endcase
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, adr, $urandom,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
